// File: rtl/mem_stage.sv
// MIPS MEM stage: registers the EX->MEM bus, waits on the variable-latency
// data-SRAM load response, extends load data and drives the WB/ID buses.
module mem_stage #(
  parameter int EX_TO_MEM_WD = 79,
  parameter int MEM_TO_WB_WD = 70,
  parameter int FWD_WD       = 38
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    data_sram_rvalid,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [FWD_WD-1:0]       mem_to_id_bus,
  output logic                    stallreq_for_mem
);

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic [2:0]  load_type;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_mem_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
  ex_mem_t                 r;
  state_t                  state;
  logic [31:0]             ld_hold;
  logic                    bubble, advance, update, is_load;

  assign r       = ex_mem_t'(ex_to_mem_bus_r);
  assign bubble  = stall[3] & ~stall[4];
  assign advance = ~stall[3];
  assign update  = bubble | advance;
  assign is_load = r.data_ram_en & (r.data_ram_wen == 4'b0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         ex_to_mem_bus_r <= '0;
    else if (bubble)  ex_to_mem_bus_r <= '0;
    else if (advance) ex_to_mem_bus_r <= ex_to_mem_bus;
  end

  // Any register update restarts evaluation from IDLE on the new contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      ld_hold <= '0;
    end else begin
      if (is_load && data_sram_rvalid && state != S_HOLD)
        ld_hold <= data_sram_rdata;
      if (update) state <= S_IDLE;
      else begin
        case (state)
          S_IDLE:  if (is_load) state <= data_sram_rvalid ? S_HOLD : S_WAIT;
          S_WAIT:  if (data_sram_rvalid) state <= S_HOLD;
          S_HOLD:  state <= S_HOLD;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign stallreq_for_mem = is_load & ~data_sram_rvalid & (state != S_HOLD);

  logic [31:0] ld_data, ld_ext, rf_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rf_we_eff;

  always_comb begin
    ld_data = data_sram_rvalid ? data_sram_rdata : ld_hold;
    ld_byte = ld_data[{r.ex_result[1:0], 3'b000} +: 8];
    ld_half = r.ex_result[1] ? ld_data[31:16] : ld_data[15:0];
    case (r.load_type)
      3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_ext = {24'h0, ld_byte};
      3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {16'h0, ld_half};
      default: ld_ext = ld_data;
    endcase
  end

  // Suppress writes while the load is outstanding so no stale data is consumed.
  assign rf_wdata  = r.sel_rf_res ? ld_ext : r.ex_result;
  assign rf_we_eff = r.rf_we & ~stallreq_for_mem;

  assign mem_to_wb_bus = {r.pc, rf_we_eff, r.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {rf_we_eff, r.rf_waddr, rf_wdata};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, between EX and WB.
- Registers the EX→MEM bus and waits for the variable-latency data-SRAM load response, stalling the pipeline while it waits.
- Aligns and sign/zero-extends load data, then selects the register-file write value.
- Produces the MEM→WB bus and a MEM→ID forwarding bus.

Parameters:
- EX_TO_MEM_WD, 79, width of ex_to_mem_bus.
- MEM_TO_WB_WD, 70, width of mem_to_wb_bus.
- FWD_WD, 38, width of mem_to_id_bus.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- stall  in  6  stall vector. Bit0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB. 1 = Stop, 0 = NoStop.
- ex_to_mem_bus  in  79  packed MSB→LSB: {pc[31:0], data_ram_en, data_ram_wen[3:0], load_type[2:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}.
- data_sram_rdata  in  32  load response data.
- data_sram_rvalid  in  1  load response valid, single-cycle pulse.
- mem_to_wb_bus  out  70  {pc, rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
- mem_to_id_bus  out  38  {rf_we, rf_waddr, rf_wdata}, same-cycle forwarding.
- stallreq_for_mem  out  1  pipeline stall request.

Behaviour:
- Input register ex_to_mem_bus_r:
  - rst=0 → cleared.
  - Else if stall[3]=Stop and stall[4]=NoStop → cleared (bubble).
  - Else if stall[3]=NoStop → load ex_to_mem_bus.
  - Else hold.
- is_load = data_ram_en & (data_ram_wen==4'b0), decoded from the register. Stores and non-memory instructions never wait.
- FSM, asynchronously reset to IDLE:
  - IDLE: is_load & ~rvalid → WAIT. is_load & rvalid → HOLD, capture rdata. Otherwise stay IDLE.
  - WAIT: rvalid → HOLD, capture rdata.
  - HOLD: an input-register update (load or bubble) → IDLE.
  - In every state, an input-register update also returns the FSM to IDLE, and the new contents are evaluated next cycle.
- stallreq_for_mem = is_load & ~rvalid & (state≠HOLD), combinational. It is 0 in the cycle rvalid arrives, so a 1-cycle response costs zero stall cycles.
- Load data source: rdata when rvalid is high this cycle, otherwise the held data register. The held data register resets to 0.
- rvalid while ~is_load: ignored, FSM unchanged.
- Extension, byte offset = ex_result[1:0]:
  - 000 LW: whole word.
  - 001 LB: byte[offset], sign-extended.
  - 010 LBU: byte[offset], zero-extended.
  - 011 LH: half[offset[1]], sign-extended.
  - 100 LHU: half[offset[1]], zero-extended.
  - Other codes: treated as LW.
  - byte0 = bits[7:0]; half0 = bits[15:0]. Misalignment is not checked.
- rf_wdata = sel_rf_res ? extended load data : ex_result.
- mem_to_wb_bus and mem_to_id_bus are combinational from the register and the data path.
- When stallreq_for_mem=1, rf_we on both outputs is forced to 0, so WB and ID never consume stale load data.
- Reset mid-wait: FSM → IDLE, all registers → 0, stallreq=0, every output bus = 0.
- Latency: one register stage. Output is valid in the cycle after capture, when the load response has arrived.

Test Plan:
- Non-load: ex_result=0x1234_5678, rf_we=1, waddr=8, sel_rf_res=0 → next cycle mem_to_wb_bus = {pc, 1, 8, 0x12345678}; stallreq stays 0.
- LB, same-cycle response: offset 3, rdata=0x80FF_0000 → rf_wdata=0xFFFF_FF80, no stall. Same data with LBU → 0x0000_0080.
- Delayed response: LW, rvalid arrives 3 cycles later with 0xDEAD_BEEF → stallreq high for exactly 3 cycles with rf_we=0 on both buses; then rf_wdata=0xDEADBEEF. FSM path IDLE→WAIT→HOLD→IDLE.
- Bubble: stall=6'b001111 → register cleared; mem_to_wb_bus=0 the following cycle.
- Hold under downstream stall: LH offset 2, rdata=0x8001_xxxx arrives, then stall[3]=1 held 2 cycles → rf_wdata stays 0xFFFF_8001 from held data, stallreq=0.
- Async reset: assert rst=0 mid-WAIT, between clock edges → stallreq and all buses 0 immediately; FSM in IDLE after release.
